div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//   Iterative radix-2 restoring divider for the EX stage: 32-bit signed/unsigned DIV/MOD.
//   The EX stage requests a division over a valid/ready handshake. This block returns
//   quotient and remainder over a second valid/ready handshake, 33 cycles later.
//   Complements the single-cycle ALU: all long-latency divide work lives here.
//   Supports a pipeline flush (exception/branch cancel).
// PARAMETERS
//   WIDTH   32            operand/result width (datapath verified at 32 only)
//   CNT_W   $clog2(WIDTH) iteration counter width (derived, do not override)
// PORTS
//   clk        in   1      clock, all state updates on posedge
//   reset      in   1      synchronous, active-high reset
//   div_valid  in   1      request valid
//   div_ready  out  1      block idle, can accept a request
//   div_signed in   1      1: signed (two's complement), 0: unsigned
//   div_src1   in   WIDTH  dividend
//   div_src2   in   WIDTH  divisor
//   div_flush  in   1      cancel in-flight/pending op
//   res_valid  out  1      result valid
//   res_ready  in   1      consumer accepts result
//   res_quot   out  WIDTH  quotient
//   res_rem    out  WIDTH  remainder
//   res_dbz    out  1      divisor was zero
// BEHAVIOUR
// - Clock/reset: one clock, clk; reset is synchronous and active-high.
// - Reset: state=IDLE; res_valid=0, res_quot=0, res_rem=0, res_dbz=0.
//   div_ready=0 while reset is high.
// - FSM states and transitions:
//   IDLE : div_ready=1; div_valid & ~div_flush -> CALC.
//          On that edge: latch |src1|, |src2| (abs only if div_signed), sign of q
//          (s1^s2), sign of r (s1), dbz flag (src2==0); clear counter and
//          partial remainder.
//   CALC : div_ready=0; one quotient bit per cycle, MSB first. Each cycle:
//          r' = {r, a[msb]}; if r' >= b: r = r' - b and q bit 1; else r = r' and q bit 0.
//          After 32 cycles (counter==31): apply signs (negate q if q-sign,
//          negate r if r-sign), register res_*, -> DONE.
//   DONE : res_valid=1, res_* held stable; res_ready -> IDLE
//          (no same-cycle accept of a new request).
// - Latency: accept cycle T -> res_valid first high in cycle T+33.
// - Throughput: one op per 34 cycles at best.
// - Flush (any state): next state IDLE; res_valid=0 next cycle; result discarded.
//   Flush has priority over div_valid, so a request in the same cycle is not accepted.
// - Arithmetic/boundaries (all natural results of the algorithm, no special-casing):
//   * x/0 unsigned: q=0xFFFFFFFF, r=x, dbz=1.
//   * x/0 signed:   q=0xFFFFFFFF if x>=0, else q=0x00000001; r=x; dbz=1.
//   * 0x80000000 / -1 signed: q=0x80000000, r=0 (abs of MIN = 0x80000000 unsigned).
//   * Remainder sign follows dividend; quotient truncates toward zero.
// - Inputs are sampled only on the accept edge; later operand changes are ignored.
// CONFIGURATION
//   DIV_ZERO_FAST_EN defined:
//     when div_src2==0 at accept, IDLE -> DONE directly with the values above;
//     res_valid is high at T+1.
//   Undefined:
//     divide-by-zero takes the full 33 cycles.
//   Result values are identical either way.
// TESTING
// 1. Unsigned 100/7: res_quot=14, res_rem=2, res_dbz=0.
//    res_valid rises exactly at T+33; div_ready=0 for T+1..T+33.
// 2. Signed -7/2 (0xFFFFFFF9/0x2): res_quot=0xFFFFFFFD, res_rem=0xFFFFFFFF.
//    Signed 7/-2: q=0xFFFFFFFD, r=1.
// 3. Signed 0x80000000/0xFFFFFFFF: q=0x80000000, r=0.
//    Unsigned same operands: q=0, r=0x80000000.
// 4. Unsigned 5/0: q=0xFFFFFFFF, r=5, dbz=1.
//    Macro off: res_valid at T+33. Macro on: res_valid at T+1.
// 5. Flush at CALC cycle 10: res_valid never rises; div_ready=1 next cycle.
//    Then 9/3: q=3, r=0 at T'+33.
// 6. Hold res_ready=0 for 5 cycles in DONE: res_* stable, div_ready=0.
//    res_ready=1 -> IDLE next cycle. Also: reset asserted mid-CALC -> res_valid=0,
//    div_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, 32-bit signed/unsigned DIV/MOD.
// Optional DIV_ZERO_FAST_EN: divide-by-zero skips the iterations.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_quot,
  output logic [WIDTH-1:0] res_rem,
  output logic             res_dbz
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             s1, s2;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   rs, rsub;
  logic             ge;
  logic [WIDTH-1:0] qbits, rnew;

  // Next-state, datapath step and handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    s1   = div_signed & div_src1[WIDTH-1];
    s2   = div_signed & div_src2[WIDTH-1];
    abs1 = s1 ? -div_src1 : div_src1;
    abs2 = s2 ? -div_src2 : div_src2;

    rs    = {r_q, a_q[WIDTH-1]};
    rsub  = rs - {1'b0, b_q};
    ge    = rs >= {1'b0, b_q};
    qbits = {a_q[WIDTH-2:0], ge};
    rnew  = ge ? rsub[WIDTH-1:0] : rs[WIDTH-1:0];

    div_ready = (state_q == IDLE) & ~reset;
    res_valid = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (div_valid && !div_flush) begin
          state_d = CALC;
          a_d     = abs1;
          b_d     = abs2;
          qneg_d  = s1 ^ s2;
          rneg_d  = s1;
          cnt_d   = '0;
          r_d     = '0;
`ifdef DIV_ZERO_FAST_EN
          if (div_src2 == '0) begin
            state_d = DONE;
            quot_d  = s1 ? WIDTH'(1) : '1;
            rem_d   = div_src1;
            dbz_d   = 1'b1;
          end
`endif
        end
      end
      CALC: begin
        a_d   = qbits;
        r_d   = rnew;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          quot_d  = qneg_q ? -qbits : qbits;
          rem_d   = rneg_q ? -rnew : rnew;
          dbz_d   = (b_q == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (div_flush) state_d = IDLE;
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign res_quot = quot_q;
  assign res_rem  = rem_q;
  assign res_dbz  = dbz_q;

endmodule

// File: tb/tb_div_iter.sv
// Randomized + directed bench for div_iter.
// Expected results come from a plain-arithmetic divide model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic        div_signed = 1'b0;
  logic [31:0] div_src1 = '0;
  logic [31:0] div_src2 = '0;
  logic        div_flush = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_quot;
  logic [31:0] res_rem;
  logic        res_dbz;

  int tests = 0;
  int fails = 0;

  bit          pending = 1'b0;
  logic [31:0] exp_q, exp_r;
  bit          exp_z;

  div_iter dut (
    .clk       (clk),
    .reset     (reset),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_signed(div_signed),
    .div_src1  (div_src1),
    .div_src2  (div_src2),
    .div_flush (div_flush),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_quot  (res_quot),
    .res_rem   (res_rem),
    .res_dbz   (res_dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model(input bit s, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] q,
                                output logic [31:0] r,
                                output bit z);
    int sa, sb;
    sa = a;
    sb = b;
    z = (b == 0);
    if (b == 0) begin
      q = (s && sa < 0) ? 32'h1 : 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Result checker: every valid cycle must match the pending op
  always @(negedge clk) begin
    if (!reset && res_valid) begin
      if (!pending) begin
        chk("spurious_valid", {31'b0, res_valid}, 32'h0);
      end else begin
        chk("quot", res_quot, exp_q);
        chk("rem", res_rem, exp_r);
        chk("dbz", {31'b0, res_dbz}, {31'b0, exp_z});
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!div_ready && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", {31'b0, div_ready}, 32'h1);
  endtask

  task automatic run_op(input bit s, input logic [31:0] a,
                        input logic [31:0] b, input int stall);
    int lat;
    wait_ready();
    model(s, a, b, exp_q, exp_r, exp_z);
    pending    = 1'b1;
    div_valid  = 1'b1;
    div_signed = s;
    div_src1   = a;
    div_src2   = b;
`ifdef DIV_ZERO_FAST_EN
    lat = (b == 0) ? 1 : 33;
`else
    lat = 33;
`endif
    @(posedge clk);
    #1;
    div_valid  = 1'b0;
    div_signed = ~s;
    div_src1   = $urandom;
    div_src2   = $urandom;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) begin
        chk("busy_ready", {31'b0, div_ready}, 32'h0);
        chk("early_valid", {31'b0, res_valid}, 32'h0);
      end else begin
        chk("valid_at_lat", {31'b0, res_valid}, 32'h1);
      end
    end
    for (int k = 0; k < stall; k++) begin
      chk("stall_ready", {31'b0, div_ready}, 32'h0);
      chk("stall_valid", {31'b0, res_valid}, 32'h1);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    pending   = 1'b0;
    @(negedge clk);
    chk("post_valid", {31'b0, res_valid}, 32'h0);
    chk("post_ready", {31'b0, div_ready}, 32'h1);
  endtask

  task automatic pin(input bit s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r, input bit z);
    logic [31:0] mq, mr;
    bit mz;
    model(s, a, b, mq, mr, mz);
    chk("model_q", mq, q);
    chk("model_r", mr, r);
    chk("model_z", {31'b0, mz}, {31'b0, z});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, div_ready}, 32'h0);
    chk("rst_valid", {31'b0, res_valid}, 32'h0);
    chk("rst_quot", res_quot, 32'h0);
    chk("rst_rem", res_rem, 32'h0);
    chk("rst_dbz", {31'b0, res_dbz}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rel_ready", {31'b0, div_ready}, 32'h1);

    pin(0, 100, 7, 14, 2, 0);
    pin(1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    pin(1, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 0);
    pin(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    pin(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0);
    pin(0, 5, 0, 32'hFFFF_FFFF, 5, 1);
    pin(1, 32'hFFFF_FFF0, 0, 1, 32'hFFFF_FFF0, 1);

    run_op(0, 100, 7, 0);
    run_op(1, 32'hFFFF_FFF9, 2, 0);
    run_op(1, 7, 32'hFFFF_FFFE, 1);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(0, 5, 0, 0);
    run_op(1, 32'hFFFF_FFF0, 0, 2);
    run_op(1, 32'h0000_0123, 0, 0);
    run_op(0, 32'hDEAD_BEEF, 32'h1234, 5);

    // Flush during CALC cycle 10
    wait_ready();
    div_valid = 1'b1;
    div_signed = 1'b0;
    div_src1 = 100;
    div_src2 = 7;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    div_flush = 1'b1;
    @(posedge clk);
    #1;
    div_flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", {31'b0, div_ready}, 32'h1);
    for (int k = 0; k < 40; k++) begin
      chk("flush_novalid", {31'b0, res_valid}, 32'h0);
      @(negedge clk);
    end
    run_op(0, 9, 3, 0);

    // Flush beats a same-cycle request
    div_valid = 1'b1;
    div_flush = 1'b1;
    div_src1 = 50;
    div_src2 = 5;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    div_flush = 1'b0;
    @(negedge clk);
    chk("flush_req_ready", {31'b0, div_ready}, 32'h1);

    // Reset asserted mid-CALC
    div_valid = 1'b1;
    div_src1 = 1234;
    div_src2 = 5;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'b0, div_ready}, 32'h0);
    chk("midrst_valid", {31'b0, res_valid}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_ready", {31'b0, div_ready}, 32'h1);
    chk("postrst_valid", {31'b0, res_valid}, 32'h0);

    for (int n = 0; n < 30; n++) begin
      run_op(1'($urandom_range(0, 1)), pick(), pick(),
             int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
